prog_loader: RTL and testbench

//  Streams a program image from a byte-wide valid/ready source into the CPU's
//  32x8 program/data memory through its external write port (ewr/ead/edat).

---
 rtl/prog_loader.sv | 121 ++++++++++++
 tb/tb_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Streams a byte image from a valid/ready source into the CPU's program memory write port,
// then checks an additive checksum byte before letting the CPU run.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | ready for the next image byte
// WRITE  | one-cycle memory write strobe for the byte just accepted
// CHECK  | ready for the checksum byte
// DONE   | image verified, CPU released
// ERR    | checksum mismatch or source timeout, sticky until next start
module prog_loader #(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          ewr,
    output logic [AW-1:0] ead,
    output logic [DW-1:0] edat,
    output logic          cpu_run,
    output logic          busy,
    output logic          err
);

    localparam int              CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0]   IDLE_LOAD = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] addr;
    logic [DW-1:0] sum;
    logic [CW-1:0] idle_left;
    logic          xfer;
    logic          timeout;
    logic          start_ok;

    assign in_ready = (state == S_LOAD) || (state == S_CHECK);
    assign ewr      = (state == S_WRITE);
    assign busy     = (state == S_LOAD) || (state == S_WRITE) || (state == S_CHECK);
    assign cpu_run  = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign xfer     = in_valid & in_ready;
    // Idle timer runs down from TIMEOUT-1; a transfer on the terminal cycle still wins.
    assign timeout  = in_ready & ~in_valid & (idle_left == '0);
    assign start_ok = start & (state inside {S_IDLE, S_DONE, S_ERR});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (xfer)         state_nx = S_WRITE;
                else if (timeout) state_nx = S_ERR;
            end
            S_WRITE: begin
                state_nx = (addr == LAST_ADDR) ? S_CHECK : S_LOAD;
            end
            S_CHECK: begin
                if (xfer)         state_nx = (in_data == sum) ? S_DONE : S_ERR;
                else if (timeout) state_nx = S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= '0;
            sum       <= '0;
            idle_left <= '0;
            ead       <= '0;
            edat      <= '0;
        end else begin
            if (start_ok) begin
                addr      <= '0;
                sum       <= '0;
                idle_left <= IDLE_LOAD;
            end else if (xfer) begin
                idle_left <= IDLE_LOAD;
                if (state == S_LOAD) begin
                    ead  <= addr;
                    edat <= in_data;
                    sum  <= sum + in_data;
                end
            end else if (in_ready && (idle_left != '0)) begin
                idle_left <= idle_left - CW'(1);
            end
            // Address stops at the last location so the write port never wraps.
            if ((state == S_WRITE) && (addr != LAST_ADDR)) begin
                addr <= addr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed/randomized bench for prog_loader: a byte source with per-byte stalls, a write-port
// monitor, and an image-level model of the expected writes, checksum verdict and timeout.
module tb_prog_loader;

    localparam int AW      = 5;
    localparam int DW      = 8;
    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 1000;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic          ewr;
    logic [AW-1:0] ead;
    logic [DW-1:0] edat;
    logic          cpu_run;
    logic          busy;
    logic          err;

    prog_loader #(
        .AW     (AW),
        .DW     (DW),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .ewr     (ewr),
        .ead     (ead),
        .edat    (edat),
        .cpu_run (cpu_run),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int start_at = -1;

    logic [DW-1:0] img [DEPTH];
    int            stall [DEPTH+1];
    int            wr_addr_q [$];
    int            wr_data_q [$];
    int            wr_cyc_q  [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b1 && ewr === 1'b1) begin
            wr_addr_q.push_back(int'(ead));
            wr_data_q.push_back(int'(edat));
            wr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge: waits for in_ready, optionally pulses start, idles s cycles, sends b.
    task automatic send_byte(input logic [DW-1:0] b, input int s, input bit pulse, output bit acc);
        int budget;
        budget = 0;
        acc    = 1'b0;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (in_ready !== 1'b1) return;
        if (pulse) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (s) @(negedge clk);
        if (in_ready !== 1'b1) return;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        acc      = 1'b1;
    endtask

    task automatic idle_noise(input string name, input int n, input int exp_run);
        int saw_ready;
        saw_ready = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            @(negedge clk);
            if (in_ready !== 1'b0) saw_ready++;
        end
        in_valid = 1'b0;
        check($sformatf("%s in_ready seen", name), saw_ready, 0);
        check($sformatf("%s ewr count", name), wr_addr_q.size(), 0);
        check($sformatf("%s cpu_run", name), int'(cpu_run), exp_run);
        check($sformatf("%s busy", name), int'(busy), 0);
    endtask

    task automatic do_load(input string name, input logic [DW-1:0] csum);
        int            first_to;
        int            s;
        int            exp_acc;
        int            exp_wr;
        int            n_acc;
        int            nchk;
        bit            exp_ok;
        bit            acc;
        logic [DW-1:0] exp_sum;

        first_to = -1;
        for (int i = 0; i <= DEPTH; i++) begin
            if (first_to < 0 && stall[i] >= TIMEOUT) first_to = i;
        end
        s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(img[i]);
        exp_sum = DW'(s % 256);
        exp_ok  = (first_to < 0) && (csum == exp_sum);
        exp_acc = (first_to < 0) ? DEPTH + 1 : first_to;
        exp_wr  = (exp_acc > DEPTH) ? DEPTH : exp_acc;

        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pulse_start();
        check($sformatf("%s busy after start", name), int'(busy), 1);
        check($sformatf("%s in_ready after start", name), int'(in_ready), 1);

        n_acc = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            send_byte((i < DEPTH) ? img[i] : csum, stall[i], (i == start_at), acc);
            if (!acc) break;
            n_acc++;
        end
        repeat (2) @(negedge clk);

        check($sformatf("%s bytes accepted", name), n_acc, exp_acc);
        check($sformatf("%s ewr count", name), wr_addr_q.size(), exp_wr);
        nchk = (wr_addr_q.size() < exp_wr) ? wr_addr_q.size() : exp_wr;
        for (int i = 0; i < nchk; i++) begin
            check($sformatf("%s ead[%0d]", name, i), wr_addr_q[i], i);
            check($sformatf("%s edat[%0d]", name, i), wr_data_q[i], int'(img[i]));
            if (i > 0) begin
                check($sformatf("%s gap[%0d]", name, i), wr_cyc_q[i] - wr_cyc_q[i-1],
                      stall[i] + 2 + ((i == start_at) ? 1 : 0));
            end
        end
        check($sformatf("%s err", name), int'(err), exp_ok ? 0 : 1);
        check($sformatf("%s cpu_run", name), int'(cpu_run), exp_ok ? 1 : 0);
        check($sformatf("%s busy at end", name), int'(busy), 0);
        check($sformatf("%s in_ready at end", name), int'(in_ready), 0);
        check($sformatf("%s ewr at end", name), int'(ewr), 0);
    endtask

    initial begin
        bit acc;
        int n_acc;

        // Reset state
        #3;
        check("reset in_ready", int'(in_ready), 0);
        check("reset ewr", int'(ewr), 0);
        check("reset ead", int'(ead), 0);
        check("reset edat", int'(edat), 0);
        check("reset cpu_run", int'(cpu_run), 0);
        check("reset busy", int'(busy), 0);
        check("reset err", int'(err), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        idle_noise("idle noise", 20, 0);

        // Counting image, good checksum
        for (int i = 0; i < DEPTH; i++) img[i] = DW'(i);
        for (int i = 0; i <= DEPTH; i++) stall[i] = 0;
        do_load("count good", 8'hF0);
        idle_noise("done noise", 20, 1);

        // Bad checksum then a correct reload
        do_load("count bad", 8'hF1);
        do_load("count reload", 8'hF0);

        // Random image, stalls just under the timeout
        for (int i = 0; i < DEPTH; i++) img[i] = DW'($urandom);
        for (int i = 0; i <= DEPTH; i++) stall[i] = int'($urandom_range(0, 3));
        stall[3]     = TIMEOUT - 1;
        stall[DEPTH] = TIMEOUT - 1;
        do_load("stall 999", 8'(img.sum() with (int'(item))));

        // Stall of TIMEOUT cycles after byte 5
        for (int i = 0; i < DEPTH; i++) img[i] = DW'(i);
        for (int i = 0; i <= DEPTH; i++) stall[i] = 0;
        stall[6] = TIMEOUT;
        do_load("stall 1000", 8'hF0);

        // Async reset in the middle of a load
        for (int i = 0; i < DEPTH; i++) img[i] = DW'($urandom);
        for (int i = 0; i <= DEPTH; i++) stall[i] = 0;
        pulse_start();
        n_acc = 0;
        for (int i = 0; i <= 10; i++) begin
            send_byte(img[i], 0, 1'b0, acc);
            if (acc) n_acc++;
        end
        check("midreset bytes before reset", n_acc, 11);
        check("midreset busy before reset", int'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check("midreset in_ready", int'(in_ready), 0);
        check("midreset ewr", int'(ewr), 0);
        check("midreset ead", int'(ead), 0);
        check("midreset edat", int'(edat), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset cpu_run", int'(cpu_run), 0);
        check("midreset err", int'(err), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_load("after reset", 8'(img.sum() with (int'(item))));

        // start pulsed mid-load must be ignored
        for (int i = 0; i < DEPTH; i++) img[i] = DW'($urandom);
        for (int i = 0; i <= DEPTH; i++) stall[i] = int'($urandom_range(0, 2));
        start_at = 7;
        do_load("start midload", 8'(img.sum() with (int'(item))));
        start_at = -1;
        idle_noise("final noise", 15, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
